// File: rtl/timer_requester_pkg.sv
`default_nettype none
// =====================================================================
// Module   : timer_requester_pkg
// Brief    : Shared widths, FSM states and helpers for timer_requester.
// Revision : 1.0 - initial release
// =====================================================================
package timer_requester_pkg;

   localparam int DELAY_W                = 32;
   localparam int REPEAT_W               = 8;
   // One extra bit so that a full-scale delay plus the margin cannot wrap
   localparam int WDOG_W                 = DELAY_W + 1;
   localparam int TIMEOUT_MARGIN_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // A repeat request of zero still performs a single run
   function automatic logic [REPEAT_W-1:0] repeat_runs(input logic [REPEAT_W-1:0] req);
      return (req == '0) ? REPEAT_W'(1) : req;
   endfunction

endpackage
`default_nettype wire

// File: rtl/timer_requester_watchdog.sv
`default_nettype none
// =====================================================================
// Module   : timeout_watchdog
// Brief    : Loadable down-counter flagging a missing timer completion.
// Revision : 1.0 - initial release
// =====================================================================
module timeout_watchdog
   import timer_requester_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WDOG_W-1:0] load_value,
   input  logic              dec,
   output logic [WDOG_W-1:0] value,
   output logic              expired
);

   logic [WDOG_W-1:0] r_value;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_value <= '0;
      end else if (load) begin
         r_value <= load_value;
      end else if (dec) begin
         r_value <= r_value - WDOG_W'(1);
      end
   end

   // Expired on the cycle whose decrement reaches zero (or is already there)
   assign value   = r_value;
   assign expired = (r_value <= WDOG_W'(1));

endmodule
`default_nettype wire

// File: rtl/timer_requester.sv
`default_nettype none
// =====================================================================
// Module   : timer_requester
// Brief    : Runs a timer a programmed number of times per command.
// Revision : 1.0 - initial release
// =====================================================================
module timer_requester
   import timer_requester_pkg::*;
#(
   parameter int TIMEOUT_MARGIN = TIMEOUT_MARGIN_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [DELAY_W-1:0]  cmd_delay,
   input  logic [REPEAT_W-1:0] cmd_repeat,
   input  logic                abort,
   output logic                timer_start,
   output logic [DELAY_W-1:0]  timer_reload,
   input  logic                timer_done,
   output logic                busy,
   output logic                rsp_valid,
   output logic [REPEAT_W-1:0] rsp_count,
   output logic                err
);

   state_t              r_state, w_state_nxt;
   logic [DELAY_W-1:0]  r_delay;
   logic [REPEAT_W-1:0] r_repeat;
   logic [REPEAT_W-1:0] r_run_cnt, w_run_cnt_nxt;
   logic [REPEAT_W-1:0] r_rsp_count;
   logic                r_err, w_err_nxt;
   logic                w_accept;
   logic                w_wd_load, w_wd_dec, w_wd_expired, w_timeout;
   logic [WDOG_W-1:0]   w_wd_value, w_wd_load_value;

   assign w_wd_load       = (r_state == ST_START);
   assign w_wd_load_value = {1'b0, r_delay} + WDOG_W'(TIMEOUT_MARGIN);
   assign w_wd_dec        = (r_state == ST_WAIT) && (w_wd_value != '0);
   assign w_timeout       = (r_state == ST_WAIT) && w_wd_expired;

   timeout_watchdog u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .load       (w_wd_load),
      .load_value (w_wd_load_value),
      .dec        (w_wd_dec),
      .value      (w_wd_value),
      .expired    (w_wd_expired)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_run_cnt_nxt = r_run_cnt;
      w_err_nxt     = r_err;
      w_accept      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_accept      = 1'b1;
               w_run_cnt_nxt = '0;
               w_err_nxt     = 1'b0;
               w_state_nxt   = ST_START;
            end
         end
         ST_START: begin
            if (abort) begin
               if (timer_done) begin
                  w_run_cnt_nxt = r_run_cnt + REPEAT_W'(1);
               end
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A completion beats a coincident watchdog expiry
            if (timer_done) begin
               w_run_cnt_nxt = r_run_cnt + REPEAT_W'(1);
               if (abort || (w_run_cnt_nxt == r_repeat)) begin
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_START;
               end
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (abort) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_delay     <= '0;
         r_repeat    <= '0;
         r_run_cnt   <= '0;
         r_rsp_count <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_run_cnt <= w_run_cnt_nxt;
         r_err     <= w_err_nxt;
         if (w_accept) begin
            r_delay  <= cmd_delay;
            r_repeat <= repeat_runs(cmd_repeat);
         end
         // Captured on entry to RESP so the count is valid alongside rsp_valid
         if (w_state_nxt == ST_RESP) begin
            r_rsp_count <= w_run_cnt_nxt;
         end
      end
   end

   assign cmd_ready    = (r_state == ST_IDLE);
   assign timer_start  = (r_state == ST_START);
   assign busy         = (r_state != ST_IDLE);
   assign rsp_valid    = (r_state == ST_RESP);
   assign timer_reload = r_delay;
   assign rsp_count    = r_rsp_count;
   assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_timer_requester.sv
`default_nettype none
// =====================================================================
// Module   : tb_timer_requester
// Brief    : Randomized self-checking bench for timer_requester.
// Revision : 1.0 - initial release
// =====================================================================
module tb_timer_requester;

   localparam int TM = 16;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_delay;
   logic [7:0]  cmd_repeat;
   logic        abort;
   logic        timer_start;
   logic [31:0] timer_reload;
   logic        timer_done;
   logic        busy;
   logic        rsp_valid;
   logic [7:0]  rsp_count;
   logic        err;

   int checks   = 0;
   int failures = 0;

   // Scenario description consumed by the driver and the reference model
   int lat_q[$];
   int abort_run;
   int abort_off;
   bit hold_valid;

   // Observations from the driver
   int   obs_starts[$];
   int   obs_rsp_cycle;
   logic [7:0] obs_count;
   logic obs_err;
   logic obs_err_early;
   int   obs_reload_bad, obs_ready_bad, obs_busy_bad;

   // Reference model results
   int exp_starts[$];
   int exp_rsp;
   int exp_count;
   bit exp_err;

   timer_requester #(.TIMEOUT_MARGIN(TM)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_delay    (cmd_delay),
      .cmd_repeat   (cmd_repeat),
      .abort        (abort),
      .timer_start  (timer_start),
      .timer_reload (timer_reload),
      .timer_done   (timer_done),
      .busy         (busy),
      .rsp_valid    (rsp_valid),
      .rsp_count    (rsp_count),
      .err          (err)
   );

   always #5 clk = ~clk;

   // Cycle 1 is the first timer_start; each run lasts until its done
   // (then next start one cycle later) or until delay+margin expires.
   task automatic model_cmd(input logic [31:0] d, input logic [7:0] r);
      longint win, s, lat;
      int     eff;
      bit     done_ok;
      win = longint'(d) + longint'(TM);
      eff = (r == 8'd0) ? 1 : int'(r);
      s = 1;
      exp_starts.delete();
      exp_err = 0; exp_count = 0; exp_rsp = -1;
      for (int k = 0; k < eff; k++) begin
         lat = (k < lat_q.size()) ? longint'(lat_q[k]) : 0;
         done_ok = (lat != 0) && (lat <= win);
         exp_starts.push_back(int'(s));
         if (k == abort_run && done_ok && longint'(abort_off) <= lat) begin
            exp_count = k + ((longint'(abort_off) == lat) ? 1 : 0);
            exp_rsp   = int'(s) + abort_off + 1;
            return;
         end
         if (!done_ok) begin
            exp_err   = 1;
            exp_count = k;
            exp_rsp   = int'(s + win + 1);
            return;
         end
         exp_count = k + 1;
         s = s + lat + 1;
      end
      exp_rsp = int'(s);
   endtask

   // Issues one command, plays the timer, and records what the DUT did
   task automatic drive_cmd(input logic [31:0] d, input logic [7:0] r, input int budget);
      int t, run, run_start;
      obs_starts.delete();
      obs_rsp_cycle = -1; obs_count = 8'hxx; obs_err = 1'bx; obs_err_early = 1'bx;
      obs_reload_bad = 0; obs_ready_bad = 0; obs_busy_bad = 0;
      for (int i = 0; i < 4 && cmd_ready !== 1'b1; i++) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL idle_ready got=%b want=1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_delay = d; cmd_repeat = r;
      @(posedge clk); @(negedge clk);
      if (!hold_valid) begin
         cmd_valid = 1'b0; cmd_delay = $urandom(); cmd_repeat = 8'($urandom());
      end
      obs_err_early = err;
      t = 1; run = -1; run_start = 0;
      while (t <= budget) begin
         timer_done = 1'b0; abort = 1'b0;
         if (busy !== 1'b1) obs_busy_bad++;
         if (cmd_ready !== 1'b0) obs_ready_bad++;
         if (timer_reload !== d) obs_reload_bad++;
         if (timer_start === 1'b1) begin
            obs_starts.push_back(t); run++; run_start = t;
         end
         if (rsp_valid === 1'b1) begin
            obs_rsp_cycle = t; obs_count = rsp_count; obs_err = err;
            break;
         end
         if (run >= 0 && run < lat_q.size() && lat_q[run] != 0 && t == run_start + lat_q[run])
            timer_done = 1'b1;
         if (run >= 0 && run == abort_run && t == run_start + abort_off)
            abort = 1'b1;
         @(posedge clk); @(negedge clk);
         t++;
      end
      timer_done = 1'b0; abort = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if ({busy, timer_start, rsp_valid, err, cmd_ready} !== 5'b00001) begin
         failures++; $display("FAIL reset_flags got=%b want=00001", {busy, timer_start, rsp_valid, err, cmd_ready});
      end
      checks++;
      if (timer_reload !== 32'd0) begin
         failures++; $display("FAIL reset_reload got=%h want=0", timer_reload);
      end
      checks++;
      if (rsp_count !== 8'd0) begin
         failures++; $display("FAIL reset_count got=%0d want=0", rsp_count);
      end
      rst = 1'b1;
   endtask

   task automatic test_single_run;
      lat_q = '{6}; abort_run = -1; abort_off = 0;
      model_cmd(32'd5, 8'd1); drive_cmd(32'd5, 8'd1, 100);
      checks++;
      if (obs_starts.size() != 1 || obs_starts[0] != 1) begin
         failures++; $display("FAIL single_starts got=%0d pulses want=1 at cycle 1", obs_starts.size());
      end
      checks++;
      if (obs_rsp_cycle != exp_rsp) begin
         failures++; $display("FAIL single_rsp_cycle got=%0d want=%0d", obs_rsp_cycle, exp_rsp);
      end
      checks++;
      if (obs_count !== 8'd1 || obs_err !== 1'b0) begin
         failures++; $display("FAIL single_result got=%0d/%b want=1/0", obs_count, obs_err);
      end
      checks++;
      if (obs_reload_bad != 0 || obs_busy_bad != 0 || obs_ready_bad != 0) begin
         failures++; $display("FAIL single_hold got=%0d/%0d/%0d bad cycles want=0", obs_reload_bad, obs_busy_bad, obs_ready_bad);
      end
   endtask

   task automatic test_repeat;
      lat_q = '{2, 5, 1, 3}; abort_run = -1;
      model_cmd(32'd3, 8'd4); drive_cmd(32'd3, 8'd4, 100);
      checks++;
      if (obs_starts.size() != exp_starts.size()) begin
         failures++; $display("FAIL repeat_pulses got=%0d want=%0d", obs_starts.size(), exp_starts.size());
      end else begin
         for (int i = 0; i < exp_starts.size(); i++) begin
            checks++;
            if (obs_starts[i] != exp_starts[i]) begin
               failures++; $display("FAIL repeat_start%0d got=%0d want=%0d", i, obs_starts[i], exp_starts[i]);
            end
         end
      end
      checks++;
      if (obs_count !== 8'd4 || obs_rsp_cycle != exp_rsp) begin
         failures++; $display("FAIL repeat_result got=%0d@%0d want=4@%0d", obs_count, obs_rsp_cycle, exp_rsp);
      end
      lat_q = '{4};
      model_cmd(32'd3, 8'd0); drive_cmd(32'd3, 8'd0, 100);
      checks++;
      if (obs_starts.size() != 1 || obs_count !== 8'd1 || obs_rsp_cycle != exp_rsp) begin
         failures++; $display("FAIL repeat_zero got=%0d runs/%0d@%0d want=1/1@%0d", obs_starts.size(), obs_count, obs_rsp_cycle, exp_rsp);
      end
   endtask

   task automatic test_timeout;
      lat_q = '{0}; abort_run = -1;
      model_cmd(32'd2, 8'd1); drive_cmd(32'd2, 8'd1, 100);
      checks++;
      if (obs_err !== 1'b1 || obs_count !== 8'd0) begin
         failures++; $display("FAIL timeout_result got=%b/%0d want=1/0", obs_err, obs_count);
      end
      checks++;
      if (obs_rsp_cycle != exp_rsp || exp_rsp != 20) begin
         failures++; $display("FAIL timeout_cycle got=%0d want=20", obs_rsp_cycle);
      end
      lat_q = '{3};
      drive_cmd(32'd7, 8'd1, 100);
      checks++;
      if (obs_err_early !== 1'b0 || obs_err !== 1'b0 || obs_count !== 8'd1) begin
         failures++; $display("FAIL timeout_clear got=%b/%b/%0d want=0/0/1", obs_err_early, obs_err, obs_count);
      end
   endtask

   task automatic test_race;
      lat_q = '{18}; abort_run = -1;
      model_cmd(32'd2, 8'd1); drive_cmd(32'd2, 8'd1, 100);
      checks++;
      if (obs_err !== 1'b0 || obs_count !== 8'd1 || obs_rsp_cycle != exp_rsp) begin
         failures++; $display("FAIL race_expiry got=%b/%0d@%0d want=0/1@%0d", obs_err, obs_count, obs_rsp_cycle, exp_rsp);
      end
      lat_q = '{4, 5, 5}; abort_run = 1; abort_off = 5;
      model_cmd(32'd6, 8'd3); drive_cmd(32'd6, 8'd3, 100);
      checks++;
      if (obs_count !== 8'd2 || obs_rsp_cycle != exp_rsp || obs_starts.size() != 2) begin
         failures++; $display("FAIL race_abort got=%0d@%0d runs=%0d want=2@%0d runs=2", obs_count, obs_rsp_cycle, obs_starts.size(), exp_rsp);
      end
      abort_run = -1;
   endtask

   task automatic test_async_reset;
      int seen;
      for (int i = 0; i < 4 && cmd_ready !== 1'b1; i++) @(negedge clk);
      cmd_valid = 1'b1; cmd_delay = 32'd10; cmd_repeat = 8'd2;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL async_pre_busy got=%b want=1", busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy, timer_start, rsp_valid, err, cmd_ready} !== 5'b00001) begin
         failures++; $display("FAIL async_flags got=%b want=00001", {busy, timer_start, rsp_valid, err, cmd_ready});
      end
      checks++;
      if (timer_reload !== 32'd0 || rsp_count !== 8'd0) begin
         failures++; $display("FAIL async_values got=%h/%0d want=0/0", timer_reload, rsp_count);
      end
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen++;
      end
      rst = 1'b1;
      checks++;
      if (seen != 0) begin
         failures++; $display("FAIL async_no_rsp got=%0d pulses want=0", seen);
      end
      lat_q = '{2, 2}; abort_run = -1;
      drive_cmd(32'd3, 8'd2, 100);
      checks++;
      if (obs_starts.size() == 0 || obs_starts[0] != 1 || obs_count !== 8'd2) begin
         failures++; $display("FAIL async_first_accept got=%0d runs count=%0d want first start at 1, count 2", obs_starts.size(), obs_count);
      end
   endtask

   task automatic test_backpressure;
      int waited;
      hold_valid = 1'b1;
      lat_q = '{3}; abort_run = -1;
      drive_cmd(32'd4, 8'd1, 100);
      checks++;
      if (obs_ready_bad != 0 || obs_count !== 8'd1) begin
         failures++; $display("FAIL bp_ready_busy got=%0d ready cycles count=%0d want=0/1", obs_ready_bad, obs_count);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL bp_ready_after got=%b want=1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0; hold_valid = 1'b0;
      checks++;
      if (timer_start !== 1'b1 || busy !== 1'b1) begin
         failures++; $display("FAIL bp_reaccept got=%b/%b want=1/1", timer_start, busy);
      end
      waited = 0;
      while (rsp_valid !== 1'b1 && waited < 60) begin
         @(negedge clk); waited++;
      end
      checks++;
      if (waited != 4 + TM + 1 || err !== 1'b1 || rsp_count !== 8'd0) begin
         failures++; $display("FAIL bp_second got=%0d cycles err=%b count=%0d want=%0d/1/0", waited, err, rsp_count, 4 + TM + 1);
      end
      lat_q = '{40};
      model_cmd(32'hFFFF_FFFF, 8'd1); drive_cmd(32'hFFFF_FFFF, 8'd1, 100);
      checks++;
      if (obs_err !== 1'b0 || obs_count !== 8'd1 || obs_rsp_cycle != exp_rsp || obs_reload_bad != 0) begin
         failures++; $display("FAIL max_delay got=%b/%0d@%0d reload_bad=%0d want=0/1@%0d", obs_err, obs_count, obs_rsp_cycle, obs_reload_bad, exp_rsp);
      end
   endtask

   task automatic test_random;
      logic [31:0] d;
      logic [7:0]  r;
      int          eff, l;
      int          ok_runs[$];
      for (int it = 0; it < 40; it++) begin
         d   = $urandom_range(0, 12);
         r   = 8'($urandom_range(0, 4));
         eff = (r == 8'd0) ? 1 : int'(r);
         lat_q.delete(); ok_runs.delete();
         abort_run = -1; abort_off = 0;
         for (int k = 0; k < eff; k++) begin
            if ($urandom_range(0, 9) == 0) l = 0;
            else l = int'($urandom_range(1, d + TM + 2));
            lat_q.push_back(l);
            if (l != 0 && l <= int'(d) + TM) ok_runs.push_back(k);
         end
         if (ok_runs.size() > 0 && $urandom_range(0, 3) == 0) begin
            abort_run = ok_runs[$urandom_range(0, ok_runs.size() - 1)];
            abort_off = int'($urandom_range(0, lat_q[abort_run]));
         end
         model_cmd(d, r); drive_cmd(d, r, 400);
         checks++;
         if (obs_starts.size() != exp_starts.size()) begin
            failures++; $display("FAIL rand%0d_pulses got=%0d want=%0d", it, obs_starts.size(), exp_starts.size());
         end else begin
            for (int i = 0; i < exp_starts.size(); i++) begin
               checks++;
               if (obs_starts[i] != exp_starts[i]) begin
                  failures++; $display("FAIL rand%0d_start%0d got=%0d want=%0d", it, i, obs_starts[i], exp_starts[i]);
               end
            end
         end
         checks++;
         if (obs_rsp_cycle != exp_rsp || obs_count !== 8'(exp_count) || obs_err !== exp_err) begin
            failures++; $display("FAIL rand%0d_rsp got=%0d@%0d err=%b want=%0d@%0d err=%b", it, obs_count, obs_rsp_cycle, obs_err, exp_count, exp_rsp, exp_err);
         end
         checks++;
         if (obs_reload_bad != 0 || obs_busy_bad != 0 || obs_ready_bad != 0 || obs_err_early !== 1'b0) begin
            failures++; $display("FAIL rand%0d_hold got=%0d/%0d/%0d early_err=%b want=0/0/0/0", it, obs_reload_bad, obs_busy_bad, obs_ready_bad, obs_err_early);
         end
      end
      abort_run = -1;
   endtask

   initial begin
      clk = 1'b0; rst = 1'b0;
      cmd_valid = 1'b0; cmd_delay = '0; cmd_repeat = '0;
      abort = 1'b0; timer_done = 1'b0; hold_valid = 1'b0;
      abort_run = -1; abort_off = 0;
      test_reset();
      test_single_run();
      test_repeat();
      test_timeout();
      test_race();
      test_async_reset();
      test_backpressure();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
